// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter slice: the FSM state
//   encoding, the header byte base used when per-message headers are built in,
//   and a small width helper for counters that must stay at least one bit wide.
// ----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    // IDLE picks an owner, HDR emits the optional header byte, XFER streams payload
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } arbState_t;

    // Header byte is HDR_BASE with the owner index in the low bits
    localparam logic [7:0] HDR_BASE = 8'hA0;

    // Counter width for values 0..n-1, never narrower than one bit
    function automatic int widthFor(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Starting from the requester just after
//   i_ptr and wrapping around, returns the first requester with i_req set.
//   Ports:
//     i_req   [N-1:0]  request vector
//     i_ptr   [IW-1:0] index of the most recent owner (lowest priority)
//     o_grant [N-1:0]  one-hot winner, zero when nobody requests
//     o_idx   [IW-1:0] binary index of the winner
//     o_any            at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    logic [IW:0] w_sum;

    // Walk candidates ptr+1 .. ptr+N modulo N; the first hit wins, so the
    // previous owner (ptr itself) is considered last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            if (!o_any && i_req[w_sum[IW-1:0]]) begin
                o_any                   = 1'b1;
                o_grant[w_sum[IW-1:0]]  = 1'b1;
                o_idx                   = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares the single UART TX FIFO write port between N byte-stream
//   requesters. Whole messages are granted round-robin; bytes of two messages
//   never interleave. A grant longer than MAX_LEN bytes is cut, trunc_tick
//   pulses, and the owner re-competes for the remainder.
//   Optional build macro: UART_ARB_HDR_EN -- when defined, every grant starts
//   with one header byte HDR_BASE|owner before the payload.
//   Ports:
//     clk, reset_n           clock, synchronous active-low reset
//     req_valid/data/last    per-requester byte stream in (data packed 8N)
//     req_ready   [N-1:0]    byte accepted this cycle
//     w_data, wr_uart        byte and write strobe to the UART TX FIFO
//     tx_full                UART TX FIFO full, stalls everything
//     grant       [N-1:0]    registered one-hot owner, zero when idle
//     busy                   registered, a message is in progress
//     trunc_tick             one-cycle pulse after a MAX_LEN cut
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAX_LEN = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     w_data,
    output logic           wr_uart,
    input  logic           tx_full,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           trunc_tick
);

    localparam int IW = $clog2(N);
    localparam int CW = widthFor(MAX_LEN);

    arbState_t     r_state, w_nextState;
    logic [N-1:0]  r_grant, w_nextGrant;
    logic [IW-1:0] r_gidx,  w_nextGidx;
    logic [CW-1:0] r_count, w_nextCount;
    logic [IW-1:0] r_ptr,   w_nextPtr;
    logic          r_trunc, w_nextTrunc;
    logic          r_busy;

    logic [N-1:0]  w_pickGrant;
    logic [IW-1:0] w_pickIdx;
    logic          w_pickAny;

    logic          w_ownerValid;
    logic          w_ownerLast;
    logic [7:0]    w_ownerData;
    logic          w_beat;

    rr_pick #(.N(N)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pickGrant),
        .o_idx   (w_pickIdx),
        .o_any   (w_pickAny)
    );

    assign w_ownerValid = req_valid[r_gidx];
    assign w_ownerLast  = req_last[r_gidx];
    assign w_ownerData  = req_data[{r_gidx, 3'b000} +: 8];
    assign w_beat       = (r_state == ST_XFER) && w_ownerValid && !tx_full;

    // Next-state and output decode. Strobes come straight from the registered
    // owner plus tx_full/req_valid so a stall takes effect in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        w_nextGidx  = r_gidx;
        w_nextCount = r_count;
        w_nextPtr   = r_ptr;
        w_nextTrunc = 1'b0;
        req_ready   = '0;
        wr_uart     = 1'b0;
        w_data      = '0;

        case (r_state)
            ST_IDLE: begin
                w_nextCount = '0;
                if (w_pickAny) begin
                    w_nextGrant = w_pickGrant;
                    w_nextGidx  = w_pickIdx;
`ifdef UART_ARB_HDR_EN
                    w_nextState = ST_HDR;
`else
                    w_nextState = ST_XFER;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
                wr_uart = !tx_full;
                w_data  = HDR_BASE | 8'(r_gidx);
                if (!tx_full) begin
                    w_nextState = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                req_ready = tx_full ? '0 : r_grant;
                wr_uart   = w_ownerValid && !tx_full;
                w_data    = w_ownerData;
                if (w_beat) begin
                    if (w_ownerLast || (r_count == CW'(MAX_LEN - 1))) begin
                        w_nextState = ST_IDLE;
                        w_nextGrant = '0;
                        w_nextPtr   = r_gidx;
                        w_nextCount = '0;
                        w_nextTrunc = !w_ownerLast;
                    end else begin
                        w_nextCount = r_count + CW'(1);
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextGrant = '0;
                w_nextCount = '0;
            end
        endcase
    end

    // State register; reset leaves the pointer on N-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_count <= '0;
            r_ptr   <= IW'(N - 1);
            r_trunc <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_nextGrant;
            r_gidx  <= w_nextGidx;
            r_count <= w_nextCount;
            r_ptr   <= w_nextPtr;
            r_trunc <= w_nextTrunc;
            r_busy  <= (w_nextState != ST_IDLE);
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign trunc_tick = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (N=4, MAX_LEN=4). A directed
//   vector table, hand-written multi-cycle sequences, and a randomized run,
//   all compared against a message-level reference model kept here.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int MAX_LEN = 4;
`ifdef UART_ARB_HDR_EN
    localparam bit HDR_ON = 1'b1;
`else
    localparam bit HDR_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     w_data;
    logic           wr_uart;
    logic           tx_full;
    logic [N-1:0]   grant;
    logic           busy;
    logic           trunc_tick;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .tx_full    (tx_full),
        .grant      (grant),
        .busy       (busy),
        .trunc_tick (trunc_tick)
    );

    int checks = 0;
    int fails  = 0;

    // Per-requester message sources (ring buffers of bytes with last flags)
    logic [7:0] srcData [N][256];
    logic       srcLast [N][256];
    int         srcHead [N];
    int         srcTail [N];
    logic [N-1:0] enMask;
    bit         checkEn;

    // Reference model: owner (-1 idle), header pending, bytes sent, rr pointer
    int mOwner;
    int mCount;
    int mPtr;
    bit mHdr;
    bit mTrunc;

    // Observed DUT activity
    logic [7:0]   wrByte[$];
    int           grantLog[$];
    logic [N-1:0] prevGrant;
    int           truncSeen;
    logic [7:0]   expBytes[$];
    int           expGrants[$];

    typedef struct {
        logic         rstN;
        logic [3:0]   vld;
        logic [3:0]   lst;
        logic [31:0]  dat;
        logic         full;
        logic [3:0]   eGrant;
        logic         eBusy;
        logic         eWr;
        logic [7:0]   eData;
        logic [3:0]   eReady;
        logic         eTrunc;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit srcEmpty(input int r);
        return srcHead[r] == srcTail[r];
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < N; i++) begin
            if (!srcEmpty(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int oneHotIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic pushMsg(input int r, input int len, input logic [7:0] base);
        for (int j = 0; j < len; j++) begin
            srcData[r][srcTail[r] % 256] = base + 8'(j);
            srcLast[r][srcTail[r] % 256] = (j == len - 1);
            srcTail[r]++;
        end
    endtask

    task automatic clearSources();
        for (int i = 0; i < N; i++) begin
            srcHead[i] = 0;
            srcTail[i] = 0;
        end
    endtask

    task automatic modelReset();
        mOwner = -1;
        mCount = 0;
        mPtr   = N - 1;
        mHdr   = 1'b0;
        mTrunc = 1'b0;
    endtask

    // Present each source's head byte; idle lanes carry random junk
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!srcEmpty(i) && enMask[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = srcData[i][srcHead[i] % 256];
                req_last[i]        = srcLast[i][srcHead[i] % 256];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    // One clock: drive, compare at negedge, advance model at posedge
    task automatic cycle();
        logic [N-1:0] eGrant;
        logic [N-1:0] eReady;
        logic         eBusy;
        logic         eWr;
        logic [7:0]   eData;
        bit           picked;
        int           c;
        applyStimulus();
        @(negedge clk);
        eGrant = '0;
        eReady = '0;
        eWr    = 1'b0;
        eData  = 8'h00;
        eBusy  = (mOwner >= 0);
        if (mOwner >= 0) begin
            eGrant[mOwner] = 1'b1;
            if (mHdr) begin
                eWr   = !tx_full;
                eData = 8'hA0 + 8'(mOwner);
            end else begin
                if (!tx_full) eReady[mOwner] = 1'b1;
                eWr   = req_valid[mOwner] && !tx_full;
                eData = req_data[8*mOwner +: 8];
            end
        end
        if (checkEn) begin
            checkOutput("grant", 32'(grant), 32'(eGrant));
            checkOutput("busy", 32'(busy), 32'(eBusy));
            checkOutput("wr_uart", 32'(wr_uart), 32'(eWr));
            checkOutput("req_ready", 32'(req_ready), 32'(eReady));
            checkOutput("trunc_tick", 32'(trunc_tick), 32'(mTrunc));
            if (eWr) checkOutput("w_data", 32'(w_data), 32'(eData));
            if (wr_uart) wrByte.push_back(w_data);
            if (grant != '0 && grant != prevGrant) grantLog.push_back(oneHotIdx(grant));
            prevGrant = grant;
            if (trunc_tick) truncSeen++;
        end
        @(posedge clk);
        if (!reset_n) begin
            modelReset();
        end else begin
            mTrunc = 1'b0;
            if (mOwner < 0) begin
                picked = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (mPtr + k) % N;
                    if (!picked && req_valid[c]) begin
                        picked = 1'b1;
                        mOwner = c;
                        mHdr   = HDR_ON;
                        mCount = 0;
                    end
                end
            end else if (mHdr) begin
                if (!tx_full) mHdr = 1'b0;
            end else if (req_valid[mOwner] && !tx_full) begin
                srcHead[mOwner]++;
                if (req_last[mOwner] || mCount == MAX_LEN - 1) begin
                    mTrunc = !req_last[mOwner];
                    mPtr   = mOwner;
                    mOwner = -1;
                    mCount = 0;
                end else begin
                    mCount++;
                end
            end
        end
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tx_full = 1'b0;
        enMask  = '0;
        checkEn = 1'b0;
        cycle();
        checkEn = 1'b1;
        cycle();
        reset_n = 1'b1;
        wrByte.delete();
        grantLog.delete();
        prevGrant = '0;
        truncSeen = 0;
        clearSources();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((!allEmpty() || mOwner >= 0) && k < 500) begin
            cycle();
            k++;
        end
        cycle();
        checkOutput(name, 32'(allEmpty()), 32'd1);
        checkOutput({name, "Busy"}, 32'(busy), 32'd0);
    endtask

    task automatic compareBytes(input string name, input int start);
        checkOutput({name, "Len"}, 32'(wrByte.size() - start), 32'(expBytes.size()));
        for (int i = 0; i < expBytes.size(); i++) begin
            if (start + i < wrByte.size())
                checkOutput($sformatf("%s[%0d]", name, i), 32'(wrByte[start + i]), 32'(expBytes[i]));
        end
    endtask

    task automatic compareGrants(input string name);
        checkOutput({name, "Len"}, 32'(grantLog.size()), 32'(expGrants.size()));
        for (int i = 0; i < expGrants.size(); i++) begin
            if (i < grantLog.size())
                checkOutput($sformatf("%s[%0d]", name, i), 32'(grantLog[i]), 32'(expGrants[i]));
        end
    endtask

    task automatic addExp(input logic [7:0] b);
        expBytes.push_back(b);
    endtask

    initial begin
        vec_t vecs[19];
        int   start;
        int   need;

        vecs[0]  = '{1'b1, 4'b0001, 4'b0000, 32'h00000041, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 32'h00000041, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h41, 4'b0001, 1'b0};
        vecs[2]  = '{1'b1, 4'b0001, 4'b0001, 32'h00000042, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h42, 4'b0001, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[4]  = '{1'b1, 4'b0010, 4'b0010, 32'h00005500, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 4'b0010, 4'b0010, 32'h00005500, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 4'b0010, 4'b0010, 32'h00005500, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h55, 4'b0010, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[8]  = '{1'b1, 4'b1001, 4'b1001, 32'h33000011, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[9]  = '{1'b1, 4'b1001, 4'b1001, 32'h33000011, 1'b0, 4'b1000, 1'b1, 1'b1, 8'h33, 4'b1000, 1'b0};
        vecs[10] = '{1'b1, 4'b0001, 4'b0001, 32'h00000011, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[11] = '{1'b1, 4'b0001, 4'b0001, 32'h00000011, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11, 4'b0001, 1'b0};
        vecs[12] = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[13] = '{1'b1, 4'b0100, 4'b0000, 32'h00770000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[14] = '{1'b1, 4'b0100, 4'b0000, 32'h00770000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h77, 4'b0100, 1'b0};
        vecs[15] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0100, 1'b1, 1'b0, 8'h00, 4'b0100, 1'b0};
        vecs[16] = '{1'b1, 4'b0100, 4'b0100, 32'h00770000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[17] = '{1'b1, 4'b0100, 4'b0100, 32'h00770000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h77, 4'b0100, 1'b0};
        vecs[18] = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};

        reset_n   = 1'b0;
        tx_full   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        enMask    = '0;
        checkEn   = 1'b0;
        clearSources();
        modelReset();
        repeat (2) @(posedge clk);
        #1;

`ifndef UART_ARB_HDR_EN
        $display("[TB] directed vector table");
        reset_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            reset_n   = vecs[i].rstN;
            req_valid = vecs[i].vld;
            req_last  = vecs[i].lst;
            req_data  = vecs[i].dat;
            tx_full   = vecs[i].full;
            @(negedge clk);
            checkOutput($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].eGrant));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].eBusy));
            checkOutput($sformatf("vec%0d.wr", i), 32'(wr_uart), 32'(vecs[i].eWr));
            checkOutput($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(vecs[i].eReady));
            checkOutput($sformatf("vec%0d.trunc", i), 32'(trunc_tick), 32'(vecs[i].eTrunc));
            if (vecs[i].eWr)
                checkOutput($sformatf("vec%0d.data", i), 32'(w_data), 32'(vecs[i].eData));
            @(posedge clk);
            #1;
        end
`endif

        need = HDR_ON ? 2 : 1;

        $display("[TB] fairness");
        doReset();
        enMask = '1;
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++)
                pushMsg(r, 1, 8'(16 * r + rep));
        drain("fairDrain");
        expGrants = '{0, 1, 2, 3, 0, 1, 2, 3};
        compareGrants("fairOrder");

        $display("[TB] backpressure");
        doReset();
        enMask = '1;
        pushMsg(2, 3, 8'h61);
        for (int k = 0; k < 50 && wrByte.size() < need; k++) cycle();
        start = wrByte.size();
        tx_full = 1'b1;
        repeat (5) cycle();
        checkOutput("bpHold", 32'(wrByte.size()), 32'(start));
        tx_full = 1'b0;
        drain("bpDrain");
        expBytes.delete();
        if (HDR_ON) addExp(8'hA2);
        addExp(8'h61); addExp(8'h62); addExp(8'h63);
        compareBytes("bpBytes", 0);

        $display("[TB] no interleave");
        doReset();
        enMask = '1;
        pushMsg(1, 3, 8'h10);
        for (int k = 0; k < 50 && wrByte.size() < need; k++) cycle();
        pushMsg(2, 2, 8'h20);
        drain("ilDrain");
        expBytes.delete();
        if (HDR_ON) addExp(8'hA1);
        addExp(8'h10); addExp(8'h11); addExp(8'h12);
        if (HDR_ON) addExp(8'hA2);
        addExp(8'h20); addExp(8'h21);
        compareBytes("ilBytes", 0);
        expGrants = '{1, 2};
        compareGrants("ilOrder");

        $display("[TB] truncation");
        doReset();
        enMask = '1;
        pushMsg(0, 6, 8'h30);
        drain("trDrain");
        checkOutput("trTicks", 32'(truncSeen), 32'd1);
        expBytes.delete();
        if (HDR_ON) addExp(8'hA0);
        addExp(8'h30); addExp(8'h31); addExp(8'h32); addExp(8'h33);
        if (HDR_ON) addExp(8'hA0);
        addExp(8'h34); addExp(8'h35);
        compareBytes("trBytes", 0);
        expGrants = '{0, 0};
        compareGrants("trOrder");

        $display("[TB] reset mid-message");
        doReset();
        enMask = '1;
        pushMsg(3, 4, 8'h50);
        for (int k = 0; k < 50 && wrByte.size() < need + 1; k++) cycle();
        checkOutput("rmReach", 32'(wrByte.size()), 32'(need + 1));
        enMask  = '0;
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        checkOutput("rmIdleWr", 32'(wr_uart), 32'd0);
        checkOutput("rmIdleGrant", 32'(grant), 32'd0);
        clearSources();
        start = wrByte.size();
        enMask = '1;
        pushMsg(3, 1, 8'h5A);
        drain("rmDrain");
        expBytes.delete();
        if (HDR_ON) addExp(8'hA3);
        addExp(8'h5A);
        compareBytes("rmBytes", start);

        $display("[TB] randomized traffic");
        doReset();
        for (int t = 0; t < 1500; t++) begin
            for (int r = 0; r < N; r++) begin
                if (srcEmpty(r) && $urandom_range(7) == 0)
                    pushMsg(r, $urandom_range(7, 1), 8'($urandom));
                enMask[r] = ($urandom_range(9) < 8);
            end
            tx_full = ($urandom_range(3) == 0);
            cycle();
        end
        enMask  = '1;
        tx_full = 1'b0;
        drain("randDrain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
